// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int INST_INC = 4;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FLUSH} fetch_state_e;
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with PC update and decode handoff
module ifu_fetch import ifu_pkg::*; #(
  parameter int XLEN = ifu_pkg::XLEN,
  parameter int ILEN = ifu_pkg::ILEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_we_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [1:0]      inst_fault_o
);
  fetch_state_e    state_q, state_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]      fault_q, fault_d;
  logic            aligned;
  assign aligned = pc_i[1:0] == 2'b00;
  // next-state and holding-register updates; redirects always win over local progress
  always_comb begin
    state_d = state_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d = fault_q;
    imem_req_valid_o = 1'b0;
    case (state_q)
      REQ: begin
        imem_req_valid_o = !redirect_valid_i && aligned;
        if (!redirect_valid_i && !aligned) begin
          inst_pc_d = pc_i;
          inst_d = '0;
          fault_d = FAULT_MISALIGN;
          state_d = HOLD;
        end else if (!redirect_valid_i && imem_req_ready_i) begin
          inst_pc_d = pc_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_i) begin
          state_d = imem_rsp_valid_i ? REQ : FLUSH;
        end else if (imem_rsp_valid_i) begin
          inst_d = imem_rsp_err_i ? '0 : imem_rsp_data_i;
          fault_d = imem_rsp_err_i ? FAULT_ACCESS : FAULT_NONE;
          state_d = HOLD;
        end
      end
      HOLD: state_d = (redirect_valid_i || inst_ready_i) ? REQ : HOLD;
      FLUSH: state_d = imem_rsp_valid_i ? REQ : FLUSH;
      default: state_d = REQ;
    endcase
  end
  // state and decode-side holding registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= REQ;
      inst_q <= '0;
      inst_pc_q <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q <= fault_d;
    end
  end
  assign imem_req_addr_o = pc_i;
  assign pc_we_o = rst_ni && (redirect_valid_i || (state_q == HOLD && inst_ready_i));
  assign pc_next_o = !pc_we_o ? '0 : redirect_valid_i ? redirect_pc_i : inst_pc_q + XLEN'(INST_INC);
  assign inst_valid_o = rst_ni && state_q == HOLD && !redirect_valid_i;
  assign inst_o = rst_ni ? inst_q : '0;
  assign inst_pc_o = rst_ni ? inst_pc_q : '0;
  assign inst_fault_o = rst_ni ? fault_q : FAULT_NONE;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table plus randomized run against a transaction-level model
module tb_ifu_fetch;
  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] I1 = 32'h0010_0093;
  logic        clk_i = 1'b0;
  logic        rst_ni, pc_we_o, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
  logic        imem_rsp_err_i, redirect_valid_i, inst_valid_o, inst_ready_i;
  logic [63:0] pc_i, pc_next_o, imem_req_addr_o, redirect_pc_i, inst_pc_o;
  logic [31:0] imem_rsp_data_i, inst_o;
  logic [1:0]  inst_fault_o;
  int vecs = 0, errs = 0;
  always #5 clk_i = ~clk_i;
  ifu_fetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .pc_we_o(pc_we_o), .pc_next_o(pc_next_o),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
  );
  typedef struct {
    logic rst_n; logic [63:0] pc; logic rdy, rsv, err; logic [31:0] data;
    logic redir; logic [63:0] rpc; logic irdy;
    logic e_req, e_we; logic [63:0] e_next; logic e_iv; logic [31:0] e_inst;
    logic [63:0] e_ipc; logic [1:0] e_f;
  } vec_t;
  vec_t tbl [34];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  bit m_busy, m_drop, m_have;
  logic [31:0] m_inst;
  logic [63:0] m_pc, m_cap, pc_reg;
  logic [1:0]  m_f;
  int cnt;
  logic e_req, e_we, e_iv;
  logic [63:0] e_next;
  initial begin
    tbl[0]  = '{0, B, 1, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, B, 1, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, B, 1, 1, 0, 32'h13, 0, 0, 0,   0, 0, 0, 0, 0, B, 0};
    tbl[3]  = '{1, B, 1, 0, 0, 0, 0, 0, 1,        0, 1, B+4, 1, 32'h13, B, 0};
    tbl[4]  = '{1, B+4, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0, 32'h13, B, 0};
    tbl[5]  = '{1, B+4, 1, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0, 32'h13, B, 0};
    tbl[6]  = '{1, B+4, 1, 1, 0, I1, 0, 0, 0,     0, 0, 0, 0, 32'h13, B+4, 0};
    tbl[7]  = '{1, B+4, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, I1, B+4, 0};
    tbl[8]  = tbl[7];
    tbl[9]  = '{1, B+4, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, I1, B+4, 0};
    tbl[10] = tbl[7];
    tbl[11] = tbl[7];
    tbl[12] = '{1, B+4, 1, 0, 0, 0, 0, 0, 1,      0, 1, B+8, 1, I1, B+4, 0};
    tbl[13] = '{1, B+8, 1, 0, 0, 0, 0, 0, 0,      1, 0, 0, 0, I1, B+4, 0};
    tbl[14] = '{1, B+8, 1, 0, 0, 0, 1, B+'h100, 0, 0, 1, B+'h100, 0, I1, B+8, 0};
    tbl[15] = '{1, B+'h100, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, I1, B+8, 0};
    tbl[16] = '{1, B+'h100, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, I1, B+8, 0};
    tbl[17] = '{1, B+'h100, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, I1, B+8, 0};
    tbl[18] = '{1, B+'h100, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, I1, B+8, 0};
    tbl[19] = '{1, B+'h100, 1, 1, 0, 32'h67, 0, 0, 0, 0, 0, 0, 0, I1, B+'h100, 0};
    tbl[20] = '{1, B+'h100, 1, 0, 0, 0, 1, B+'h200, 1, 0, 1, B+'h200, 0, 32'h67, B+'h100, 0};
    tbl[21] = '{1, B+2, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 32'h67, B+'h100, 0};
    tbl[22] = '{1, B+2, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, B+2, 2'b01};
    tbl[23] = '{1, B+2, 1, 0, 0, 0, 1, B+'h300, 0, 0, 1, B+'h300, 0, 0, B+2, 2'b01};
    tbl[24] = '{1, B+'h300, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, B+2, 2'b01};
    tbl[25] = '{1, B+'h300, 1, 1, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, B+'h300, 2'b01};
    tbl[26] = '{1, B+'h300, 1, 0, 0, 0, 0, 0, 1,  0, 1, B+'h304, 1, 0, B+'h300, 2'b10};
    tbl[27] = '{1, W, 1, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, B+'h300, 2'b10};
    tbl[28] = '{1, W, 1, 1, 0, 32'h13, 0, 0, 0,   0, 0, 0, 0, 0, W, 2'b10};
    tbl[29] = '{1, W, 1, 0, 0, 0, 0, 0, 1,        0, 1, 0, 1, 32'h13, W, 0};
    tbl[30] = '{1, 0, 1, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 32'h13, W, 0};
    tbl[31] = '{0, 0, 1, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0};
    tbl[32] = '{1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[33] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0};
    rst_ni = 0; pc_i = B; imem_req_ready_i = 0; imem_rsp_valid_i = 0; imem_rsp_err_i = 0;
    imem_rsp_data_i = 0; redirect_valid_i = 0; redirect_pc_i = 0; inst_ready_i = 0;
    repeat (2) @(posedge clk_i);
    for (int i = 0; i < 34; i++) begin
      @(posedge clk_i); #1;
      rst_ni = tbl[i].rst_n; pc_i = tbl[i].pc; imem_req_ready_i = tbl[i].rdy;
      imem_rsp_valid_i = tbl[i].rsv; imem_rsp_err_i = tbl[i].err; imem_rsp_data_i = tbl[i].data;
      redirect_valid_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc; inst_ready_i = tbl[i].irdy;
      @(negedge clk_i);
      chk($sformatf("r%0d req_valid", i), 64'(imem_req_valid_o), 64'(tbl[i].e_req));
      chk($sformatf("r%0d req_addr", i), imem_req_addr_o, tbl[i].pc);
      chk($sformatf("r%0d pc_we", i), 64'(pc_we_o), 64'(tbl[i].e_we));
      if (tbl[i].e_we) chk($sformatf("r%0d pc_next", i), pc_next_o, tbl[i].e_next);
      chk($sformatf("r%0d inst_valid", i), 64'(inst_valid_o), 64'(tbl[i].e_iv));
      chk($sformatf("r%0d inst", i), 64'(inst_o), 64'(tbl[i].e_inst));
      chk($sformatf("r%0d inst_pc", i), inst_pc_o, tbl[i].e_ipc);
      chk($sformatf("r%0d fault", i), 64'(inst_fault_o), 64'(tbl[i].e_f));
    end
    @(posedge clk_i); #1;
    rst_ni = 0; imem_rsp_valid_i = 0; redirect_valid_i = 0; inst_ready_i = 0;
    m_busy = 0; m_drop = 0; m_have = 0; m_inst = 0; m_pc = 0; m_cap = 0; m_f = 0; cnt = 0;
    pc_reg = B;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      rst_ni = 1;
      redirect_valid_i = ($urandom % 10) == 0;
      case ($urandom % 8)
        0: redirect_pc_i = W;
        1: redirect_pc_i = B + 64'($urandom % 64) * 4 + 2;
        default: redirect_pc_i = B + 64'($urandom % 256) * 4;
      endcase
      imem_req_ready_i = ($urandom % 3) != 0;
      inst_ready_i = 1'($urandom % 2);
      imem_rsp_valid_i = m_busy ? (cnt == 0) : (($urandom % 10) == 0);
      imem_rsp_err_i = ($urandom % 6) == 0;
      imem_rsp_data_i = $urandom;
      pc_i = pc_reg;
      e_req = !m_have && !m_busy && !redirect_valid_i && pc_reg[1:0] == 2'b00;
      e_we = redirect_valid_i || (m_have && inst_ready_i);
      e_next = redirect_valid_i ? redirect_pc_i : m_pc + 64'd4;
      e_iv = m_have && !redirect_valid_i;
      @(negedge clk_i);
      chk($sformatf("c%0d req_valid", c), 64'(imem_req_valid_o), 64'(e_req));
      chk($sformatf("c%0d req_addr", c), imem_req_addr_o, pc_i);
      chk($sformatf("c%0d pc_we", c), 64'(pc_we_o), 64'(e_we));
      if (e_we) chk($sformatf("c%0d pc_next", c), pc_next_o, e_next);
      chk($sformatf("c%0d inst_valid", c), 64'(inst_valid_o), 64'(e_iv));
      if (e_iv) begin
        chk($sformatf("c%0d inst", c), 64'(inst_o), 64'(m_inst));
        chk($sformatf("c%0d inst_pc", c), inst_pc_o, m_pc);
        chk($sformatf("c%0d fault", c), 64'(inst_fault_o), 64'(m_f));
      end
      if (e_we) pc_reg = e_next;
      if (m_have) begin
        if (e_we) m_have = 0;
      end else if (m_busy) begin
        if (imem_rsp_valid_i) begin
          m_busy = 0;
          if (!m_drop && !redirect_valid_i) begin
            m_have = 1;
            m_inst = imem_rsp_err_i ? 32'h0 : imem_rsp_data_i;
            m_pc = m_cap;
            m_f = imem_rsp_err_i ? 2'b10 : 2'b00;
          end
        end else begin
          cnt--;
          if (redirect_valid_i) m_drop = 1;
        end
      end else if (!redirect_valid_i) begin
        if (pc_i[1:0] != 2'b00) begin
          m_have = 1; m_inst = 0; m_pc = pc_i; m_f = 2'b01;
        end else if (imem_req_ready_i) begin
          m_busy = 1; m_drop = 0; m_cap = pc_i; cnt = int'($urandom % 3);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
